pwm_ramp_ctrl: RTL

- Sequencer in front of pwm_gen; drives its 4-bit duty code and 2-bit frequency select.
- Soft-starts and ramps duty one code per programmable interval toward a loaded target.
- Never changes frequency while duty is non-zero: ramps to 0, switches frequency, then ramps back up.
- Sits between the top-level pin decode and pwm_gen.

---
 rtl/pwm_ramp_ctrl.sv | 77 +++++++
 1 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start duty/frequency sequencer in front of pwm_gen.
// Define PWM_RAMP_SOFT_STOP_EN to ramp down on disable instead of zeroing at once.
module pwm_ramp_ctrl #(
  parameter int STEP_CYCLES = 256,
  parameter int CNT_W = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [3:0] i_tgt_duty,
  input  logic [1:0] i_tgt_freq,
  output logic [3:0] o_duty,
  output logic [1:0] o_freq,
  output logic       o_busy,
  output logic       o_done
);
  typedef enum logic [1:0] {IDLE, RAMP, FREQ_SW, HOLD} state_t;
  state_t r_state, w_next;
  logic [3:0] r_tgt_duty, w_wd, w_step, w_duty;
  logic [1:0] r_tgt_freq, w_freq;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic w_fmis, w_tick, w_halt, w_busy, w_done;
`ifdef PWM_RAMP_SOFT_STOP_EN
  assign w_halt = 1'b0;
`else
  assign w_halt = !i_en;
`endif
  assign w_fmis = r_tgt_freq != o_freq;
  // A disabled or frequency-mismatched block aims for zero duty
  assign w_wd = (!i_en || w_fmis) ? 4'd0 : r_tgt_duty;
  assign w_tick = r_cnt == CNT_W'(STEP_CYCLES - 1);
  assign w_step = (!w_tick || o_duty == w_wd) ? o_duty :
                  (o_duty < w_wd) ? o_duty + 4'd1 : o_duty - 4'd1;
  always_ff @(posedge i_clk) r_state <= !i_rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, HOLD: w_next = !i_en ? ((o_duty == 4'd0) ? IDLE : RAMP) :
                           (w_fmis && o_duty == 4'd0) ? FREQ_SW :
                           (o_duty != w_wd) ? RAMP : HOLD;
      RAMP:       w_next = (w_step != w_wd) ? RAMP : !i_en ? IDLE :
                           w_fmis ? FREQ_SW : HOLD;
      FREQ_SW:    w_next = !i_en ? IDLE : (r_tgt_duty != 4'd0) ? RAMP : HOLD;
      default:    w_next = IDLE;
    endcase
    if (w_halt) w_next = IDLE;
  end
  always_comb begin
    w_duty = w_halt ? 4'd0 : (r_state == RAMP) ? w_step : o_duty;
    w_freq = (r_state == FREQ_SW && i_en) ? r_tgt_freq : o_freq;
    w_cnt = (r_state == RAMP && w_next == RAMP && !w_tick) ? r_cnt + CNT_W'(1) : '0;
    w_busy = w_next == RAMP || w_next == FREQ_SW;
    w_done = w_next == HOLD && (r_state == RAMP || r_state == FREQ_SW);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_duty <= 4'd0;
      o_freq <= 2'd0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      r_cnt <= '0;
      r_tgt_duty <= 4'd0;
      r_tgt_freq <= 2'd0;
    end else begin
      o_duty <= w_duty;
      o_freq <= w_freq;
      o_busy <= w_busy;
      o_done <= w_done;
      r_cnt <= w_cnt;
      if (i_load) begin
        r_tgt_duty <= (i_tgt_duty > 4'd10) ? 4'd10 : i_tgt_duty;
        r_tgt_freq <= i_tgt_freq;
      end
    end
  end
endmodule
